// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the SAR result reader.
//   - Wishbone register offsets (decoded from byte address bits [3:2])
//   - CTRL / STATUS bit positions
//   - sequencer FSM state encoding
//   - default conversion result width
package sar_pkg;

  localparam int unsigned DATA_W_DEF = 10;

  localparam logic [1:0] REG_CTRL   = 2'd0;  // byte offset 0x0
  localparam logic [1:0] REG_STATUS = 2'd1;  // byte offset 0x4
  localparam logic [1:0] REG_DATA   = 2'd2;  // byte offset 0x8
  localparam logic [1:0] REG_PERIOD = 2'd3;  // byte offset 0xC

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_FLUSH = 3;
  localparam int unsigned CTRL_IE    = 4;

  localparam int unsigned STAT_EMPTY = 8;
  localparam int unsigned STAT_FULL  = 9;
  localparam int unsigned STAT_OVF   = 10;

  localparam int unsigned DATA_VALID = 31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_BUSY = 2'd2,
    S_HOLD = 2'd3
  } sar_state_e;

endpackage

// File: rtl/sar_rd_fifo.sv
// sar_rd_fifo: result FIFO for the SAR reader.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   push_i/_data_i write request and data (accepted when not full, or when
//                  a pop happens in the same cycle)
//   pop_i          read request (ignored when empty)
//   flush_i        empties the FIFO; wins over a same-cycle push/pop
//   head_o         oldest entry
//   count_o        occupancy 0..DEPTH
//   full_o/empty_o occupancy flags
module sar_rd_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot the push needs, so full+pop+push keeps both.
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sar_result_reader.sv
// sar_result_reader: sequences SAR conversions and buffers the results for a
// Wishbone classic slave interface.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   conv_start            one-cycle conversion request to sar_logic
//   sar_valid, sar_data   conversion-done pulse and result
//   wbs_*                 Wishbone slave (CTRL 0x0, STATUS 0x4, DATA 0x8,
//                         PERIOD 0xC), single-cycle registered ack
//   irq                   level interrupt
// Build option: define SAR_READER_IRQ_EN to implement CTRL.IE and irq;
// otherwise irq is 0 and IE reads 0.
//
// state | meaning
// IDLE  | waiting for EN with START or CONT
// TRIG  | conv_start high for this one cycle
// BUSY  | waiting for sar_valid; result pushed into the FIFO
// HOLD  | continuous mode idle gap, PERIOD cycles on a down-counter
module sar_result_reader
  import sar_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              conv_start,
  input  logic              sar_valid,
  input  logic [DATA_W-1:0] sar_data,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  sar_state_e        state_q, state_d;
  logic [15:0]       timer_q, timer_d;
  logic              en_q, cont_q, start_q, ie_q, ovf_q, ovf_d, ack_q;
  logic [15:0]       period_q;
  logic [31:0]       dat_q, rdata;
  logic              access, wr, rd;
  logic [1:0]        sel;
  logic              wr_ctrl, wr_status, wr_period, pop, flush;
  logic              push_req, ovf_set;
  logic [DATA_W-1:0] fifo_head;
  logic [AW:0]       fifo_count;
  logic              fifo_full, fifo_empty;
  logic              unused_bits;

  // The cycle after an ack is never a new access, so a held stb gets one
  // ack per two cycles.
  assign access    = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr        = access & wbs_we_i;
  assign rd        = access & ~wbs_we_i;
  assign sel       = wbs_adr_i[3:2];
  assign wr_ctrl   = wr && (sel == REG_CTRL);
  assign wr_status = wr && (sel == REG_STATUS);
  assign wr_period = wr && (sel == REG_PERIOD);
  assign pop       = rd && (sel == REG_DATA);
  assign flush     = wr_ctrl & wbs_dat_i[CTRL_FLUSH];

  assign unused_bits = ^{wbs_dat_i, wbs_adr_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      start_q  <= 1'b0;
      period_q <= '0;
    end else begin
      start_q <= wr_ctrl & wbs_dat_i[CTRL_START];
      if (wr_ctrl) begin
        en_q   <= wbs_dat_i[CTRL_EN];
        cont_q <= wbs_dat_i[CTRL_CONT];
      end
      if (wr_period) period_q <= wbs_dat_i[15:0];
    end
  end

`ifdef SAR_READER_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ie_q <= 1'b0;
    else if (wr_ctrl) ie_q <= wbs_dat_i[CTRL_IE];
  end
  assign irq = ie_q & (~fifo_empty | ovf_q);
`else
  assign ie_q = 1'b0;
  assign irq  = 1'b0;
`endif

  // Overflow only when the sample is really lost: a same-cycle pop makes
  // room, and a flush drops the sample without it counting as overflow.
  assign ovf_set = push_req & fifo_full & ~pop & ~flush;
  assign ovf_d   = ovf_set | (ovf_q & ~(wr_status & wbs_dat_i[STAT_OVF]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  // Sequencer: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Sequencer: next state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: if (start_q || cont_q) state_d = S_TRIG;
      S_TRIG: state_d = S_BUSY;
      S_BUSY: begin
        if (sar_valid) begin
          timer_d = period_q;
          state_d = cont_q ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (timer_q == '0) state_d = S_TRIG;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (!en_q) state_d = S_IDLE;
  end

  // Sequencer: outputs
  always_comb begin
    conv_start = (state_q == S_TRIG);
    push_req   = (state_q == S_BUSY) & sar_valid & en_q;
  end

  sar_rd_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_req),
    .push_data_i (sar_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      REG_CTRL: begin
        rdata[CTRL_EN]   = en_q;
        rdata[CTRL_CONT] = cont_q;
        rdata[CTRL_IE]   = ie_q;
      end
      REG_STATUS: begin
        rdata[7:0]        = 8'(fifo_count);
        rdata[STAT_EMPTY] = fifo_empty;
        rdata[STAT_FULL]  = fifo_full;
        rdata[STAT_OVF]   = ovf_q;
      end
      REG_DATA: begin
        if (!fifo_empty) begin
          rdata[DATA_VALID]   = 1'b1;
          rdata[DATA_W-1:0]   = fifo_head;
        end
      end
      default: rdata[15:0] = period_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= access;
      dat_q <= rd ? rdata : '0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: doc/sar_result_reader.md
SAR_RESULT_READER -- requirements
Module: sar_result_reader

Interface
REQ-001 Parameter DATA_W, default 10: SAR conversion result width.
REQ-002 Parameter DEPTH, default 8, power of two: result FIFO depth.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 conv_start  output  1  one-cycle pulse requesting a conversion from sar_logic.
REQ-006 sar_valid  input  1  one-cycle pulse from sar_logic, conversion done.
REQ-007 sar_data  input  DATA_W  result, valid only while sar_valid=1.
REQ-008 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-009 wbs_adr_i  input  4  byte address, bits [3:2] decoded.
REQ-010 wbs_dat_i  input  32  write data.
REQ-011 wbs_ack_o  output  1  single-cycle acknowledge.
REQ-012 wbs_dat_o  output  32  read data, valid with ack.
REQ-013 irq  output  1  level interrupt.

Function
REQ-014 Register map: 0x0 CTRL, 0x4 STATUS, 0x8 DATA, 0xC PERIOD; other addresses read 0, writes ignored.
REQ-015 CTRL: bit0 EN, bit1 CONT, bit4 IE (read/write); bit2 START, bit3 FLUSH (write-1 self-clearing, read 0).
REQ-016 STATUS: [7:0] count, bit8 empty, bit9 full, bit10 OVF sticky; write 1 to bit10 clears OVF.
REQ-017 DATA read: bit31 = not-empty, [DATA_W-1:0] = FIFO head, other bits 0; pops head when not empty; empty read returns 0, no state change.
REQ-018 PERIOD: [15:0] idle cycles between conversions in continuous mode.
REQ-019 Ack asserted exactly one cycle after the first cycle with cyc&stb=1, held one cycle; no back-to-back ack without stb deasserted or re-sampled.
REQ-020 FSM states IDLE, TRIG, BUSY, HOLD.
REQ-021 IDLE -> TRIG when EN=1 and (START written or CONT=1).
REQ-022 TRIG: conv_start=1 for exactly one cycle, then BUSY.
REQ-023 BUSY -> HOLD on sar_valid when CONT=1, else -> IDLE.
REQ-024 HOLD: counts PERIOD cycles, then TRIG; PERIOD=0 gives TRIG on next cycle.
REQ-025 EN cleared in any state -> IDLE next cycle; sar_valid arriving outside BUSY is ignored.
REQ-026 sar_valid in BUSY pushes sar_data; if FIFO full, sample dropped, OVF set.
REQ-027 Simultaneous push and DATA pop: both occur, count unchanged, including when full.
REQ-028 FLUSH empties FIFO in one cycle; a push in the same cycle is dropped; OVF unaffected.
REQ-029 FIFO pointers wrap modulo DEPTH; count range 0..DEPTH.

Reset
REQ-030 rst_n low: FSM IDLE, FIFO empty, CTRL=0, PERIOD=0, OVF=0.
REQ-031 rst_n low: conv_start=0, wbs_ack_o=0, wbs_dat_o=0, irq=0.
REQ-032 Reset mid-BUSY abandons conversion; a later sar_valid is ignored.

Configuration
REQ-033 Macro SAR_READER_IRQ_EN defined: irq = IE & (not-empty | OVF).
REQ-034 Macro undefined: irq tied 0, CTRL bit4 reads 0, write ignored.

Structure
REQ-035 Package sar_pkg holds register offsets, CTRL/STATUS bit positions, FSM state encoding, DATA_W default.
REQ-036 FIFO in sub-module sar_rd_fifo (push, pop, flush, count, full, empty).

Verification
REQ-037 Write CTRL=0x5, sar_valid with 0x2A5 three cycles after conv_start -> one conv_start pulse; DATA read = 0x800002A5; FSM IDLE.
REQ-038 CTRL=0x3, PERIOD=4, sar_valid 2 cycles after each conv_start -> conv_start pulses 8 cycles apart.
REQ-039 Nine conversions, no reads, DEPTH=8 -> STATUS=0x608; write 0x400 -> OVF cleared.
REQ-040 Read DATA when empty -> 0x00000000, STATUS count 0; push and pop same cycle at count 3 -> count 3.
REQ-041 Clear EN during BUSY, then sar_valid -> FIFO stays empty, no further conv_start.
REQ-042 With SAR_READER_IRQ_EN, IE=1, one result -> irq=1; DATA read -> irq=0; without macro irq stays 0.
